// File: rtl/nibble_serial_alu_if.sv
// nibble_serial_alu_if: control, status and register-file nibble port bundle of the serial ALU.
interface nibble_serial_alu_if #(parameter int ADDR_BITS = 4);
   logic                 start;
   logic [2:0]           op;
   logic [ADDR_BITS-1:0] rs1, rs2, rd;
   logic                 busy, done, carry, zero;
   logic [2:0]           counter;
   logic [ADDR_BITS-1:0] r1_addr, r2_addr, w_addr;
   logic [3:0]           data_out1, data_out2, data_in;
   logic                 set_data;
   modport master (
      output start, op, rs1, rs2, rd, data_out1, data_out2,
      input  busy, done, carry, zero, counter, r1_addr, r2_addr, w_addr, data_in, set_data
   );
   modport slave (
      input  start, op, rs1, rs2, rd, data_out1, data_out2,
      output busy, done, carry, zero, counter, r1_addr, r2_addr, w_addr, data_in, set_data
   );
endinterface

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: 32-bit ALU working one nibble per cycle against an external nibble-wide register file.
module nibble_serial_alu #(parameter int ADDR_BITS = 4) (
   input logic clk,
   input logic rst,
   nibble_serial_alu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t               state, state_nx;
   logic [2:0]           cnt, op_r;
   logic [ADDR_BITS-1:0] rs1_r, rs2_r, rd_r;
   logic                 carry_r, zacc_r, run, is_sub, is_arith, cin;
   logic [4:0]           sum;
   logic [3:0]           res;
   always_comb begin
      run      = state == RUN;
      is_sub   = op_r == 3'b001;
      is_arith = op_r[2:1] == 2'b00;
      cin      = cnt == 3'd0 ? is_sub : carry_r;
      sum      = {1'b0, bus.data_out1} + {1'b0, is_sub ? ~bus.data_out2 : bus.data_out2} + {4'b0, cin};
      res      = is_arith        ? sum[3:0] :
                 op_r == 3'b010 ? bus.data_out1 & bus.data_out2 :
                 op_r == 3'b011 ? bus.data_out1 | bus.data_out2 :
                 op_r == 3'b100 ? bus.data_out1 ^ bus.data_out2 : bus.data_out1;
      state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
                 state == RUN  ? (cnt == 3'd7 ? DONE : RUN) : IDLE;
      bus.busy     = state != IDLE;
      bus.done     = state == DONE;
      bus.carry    = carry_r;
      bus.zero     = ~zacc_r;
      bus.counter  = run ? cnt : 3'd0;
      bus.r1_addr  = run ? rs1_r : '0;
      bus.r2_addr  = run ? rs2_r : '0;
      bus.w_addr   = run ? rd_r : '0;
      bus.data_in  = run ? res : 4'd0;
      bus.set_data = run;
   end
   // zacc_r resets high so that zero reads 0 until the first operation completes
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         op_r    <= 3'd0;
         rs1_r   <= '0;
         rs2_r   <= '0;
         rd_r    <= '0;
         carry_r <= 1'b0;
         zacc_r  <= 1'b1;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.start) begin
            op_r    <= bus.op;
            rs1_r   <= bus.rs1;
            rs2_r   <= bus.rs2;
            rd_r    <= bus.rd;
            cnt     <= 3'd0;
            carry_r <= 1'b0;
            zacc_r  <= 1'b0;
         end else if (run) begin
            cnt     <= cnt + 3'd1;
            carry_r <= is_arith & sum[4];
            zacc_r  <= zacc_r | (|res);
         end
      end
   end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb_nibble_serial_alu: directed scenarios against a behavioural nibble-addressed register file.
module tb_nibble_serial_alu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   nibble_serial_alu_if bus ();
   nibble_serial_alu dut (.clk(clk), .rst(rst), .bus(bus));
   logic [31:0] regs [16];
   logic        ld_en = 1'b0;
   logic [3:0]  ld_addr = 4'd0;
   logic [31:0] ld_val = 32'd0;
   int          wr_cnt = 0;
   int          n_cmp = 0, n_bad = 0;
   assign bus.data_out1 = regs[bus.r1_addr][{bus.counter, 2'b00} +: 4];
   assign bus.data_out2 = regs[bus.r2_addr][{bus.counter, 2'b00} +: 4];
   always @(posedge clk) begin
      if (ld_en) regs[ld_addr] <= ld_val;
      else if (bus.set_data) regs[bus.w_addr][{bus.counter, 2'b00} +: 4] <= bus.data_in;
      if (bus.set_data) wr_cnt <= wr_cnt + 1;
   end

   task automatic load(input logic [3:0] a, input logic [31:0] v);
      ld_en = 1'b1; ld_addr = a; ld_val = v;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         output int lat, output int wr);
      int w0;
      bus.op = o; bus.rs1 = a; bus.rs2 = b; bus.rd = d; bus.start = 1'b1;
      w0 = wr_cnt; lat = 0;
      do begin @(negedge clk); bus.start = 1'b0; lat++; end while (!bus.done && lat < 20);
      wr = wr_cnt - w0;
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.start = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.carry !== 1'b0) begin n_bad++; $display("FAIL rst_carry: got %b want 0", bus.carry); end
      n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL rst_zero: got %b want 0", bus.zero); end
      n_cmp++; if (bus.set_data !== 1'b0) begin n_bad++; $display("FAIL rst_set_data: got %b want 0", bus.set_data); end
      n_cmp++; if (bus.counter !== 3'd0) begin n_bad++; $display("FAIL rst_counter: got %0d want 0", bus.counter); end
      n_cmp++; if ({bus.r1_addr, bus.r2_addr, bus.w_addr, bus.data_in} !== 16'h0) begin n_bad++; $display("FAIL rst_addr_data: got %h want 0", {bus.r1_addr, bus.r2_addr, bus.w_addr, bus.data_in}); end
      bus.start = 1'b0; rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_prio_start: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_add;
      int lat, wr;
      load(4'd1, 32'h0000_000F); load(4'd2, 32'h0000_0001);
      run_op(3'b000, 4'd1, 4'd2, 4'd3, lat, wr);
      n_cmp++; if (regs[3] !== 32'h0000_0010) begin n_bad++; $display("FAIL add_res: got %h want 00000010", regs[3]); end
      n_cmp++; if (bus.carry !== 1'b0) begin n_bad++; $display("FAIL add_carry: got %b want 0", bus.carry); end
      n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL add_zero: got %b want 0", bus.zero); end
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL add_latency: got %0d want 9", lat); end
      n_cmp++; if (wr !== 8) begin n_bad++; $display("FAIL add_writes: got %0d want 8", wr); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL done_busy: got %b want 1", bus.busy); end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
      n_cmp++; if (bus.carry !== 1'b0 || bus.zero !== 1'b0) begin n_bad++; $display("FAIL flags_hold: got c=%b z=%b want 0 0", bus.carry, bus.zero); end
   endtask

   task automatic test_sub;
      int lat, wr;
      load(4'd1, 32'h1234_5678); load(4'd2, 32'h1234_5678);
      run_op(3'b001, 4'd1, 4'd2, 4'd4, lat, wr);
      n_cmp++; if (regs[4] !== 32'h0) begin n_bad++; $display("FAIL sub_eq_res: got %h want 00000000", regs[4]); end
      n_cmp++; if (bus.carry !== 1'b1) begin n_bad++; $display("FAIL sub_eq_carry: got %b want 1", bus.carry); end
      n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL sub_eq_zero: got %b want 1", bus.zero); end
      @(negedge clk);
      load(4'd1, 32'h0); load(4'd2, 32'h1);
      run_op(3'b001, 4'd1, 4'd2, 4'd4, lat, wr);
      n_cmp++; if (regs[4] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sub_borrow_res: got %h want ffffffff", regs[4]); end
      n_cmp++; if (bus.carry !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_carry: got %b want 0", bus.carry); end
      n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_zero: got %b want 0", bus.zero); end
      @(negedge clk);
   endtask

   task automatic test_add_wrap;
      int lat, wr;
      load(4'd1, 32'hFFFF_FFFF); load(4'd2, 32'h0000_0001);
      run_op(3'b000, 4'd1, 4'd2, 4'd1, lat, wr);
      n_cmp++; if (regs[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_res: got %h want 00000000", regs[1]); end
      n_cmp++; if (bus.carry !== 1'b1) begin n_bad++; $display("FAIL wrap_carry: got %b want 1", bus.carry); end
      n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL wrap_zero: got %b want 1", bus.zero); end
      @(negedge clk);
   endtask

   task automatic test_logic;
      int lat, wr;
      load(4'd5, 32'hA5A5_A5A5);
      run_op(3'b100, 4'd5, 4'd5, 4'd5, lat, wr);
      n_cmp++; if (regs[5] !== 32'h0) begin n_bad++; $display("FAIL xor_res: got %h want 00000000", regs[5]); end
      n_cmp++; if (bus.zero !== 1'b1 || bus.carry !== 1'b0) begin n_bad++; $display("FAIL xor_flags: got z=%b c=%b want 1 0", bus.zero, bus.carry); end
      @(negedge clk);
      load(4'd6, 32'hF0F0_F0F0); load(4'd7, 32'hFF00_FF00);
      run_op(3'b010, 4'd6, 4'd7, 4'd8, lat, wr);
      n_cmp++; if (regs[8] !== 32'hF000_F000) begin n_bad++; $display("FAIL and_res: got %h want f000f000", regs[8]); end
      n_cmp++; if (bus.zero !== 1'b0 || bus.carry !== 1'b0) begin n_bad++; $display("FAIL and_flags: got z=%b c=%b want 0 0", bus.zero, bus.carry); end
      @(negedge clk);
      run_op(3'b011, 4'd6, 4'd7, 4'd8, lat, wr);
      n_cmp++; if (regs[8] !== 32'hFFF0_FFF0) begin n_bad++; $display("FAIL or_res: got %h want fff0fff0", regs[8]); end
      @(negedge clk);
      run_op(3'b101, 4'd7, 4'd6, 4'd8, lat, wr);
      n_cmp++; if (regs[8] !== 32'hFF00_FF00) begin n_bad++; $display("FAIL pass_res: got %h want ff00ff00", regs[8]); end
      @(negedge clk);
      run_op(3'b111, 4'd6, 4'd7, 4'd8, lat, wr);
      n_cmp++; if (regs[8] !== 32'hF0F0_F0F0) begin n_bad++; $display("FAIL pass7_res: got %h want f0f0f0f0", regs[8]); end
      @(negedge clk);
   endtask

   task automatic test_ignore_start;
      int lat, w0;
      load(4'd9, 32'h1); load(4'd10, 32'h2); load(4'd12, 32'h5A5A_5A5A); load(4'd13, 32'h0);
      bus.op = 3'b000; bus.rs1 = 4'd9; bus.rs2 = 4'd10; bus.rd = 4'd13; bus.start = 1'b1;
      w0 = wr_cnt; lat = 0;
      do begin @(negedge clk); bus.rd = 4'd12; bus.op = 3'b010; lat++; end while (!bus.done && lat < 20);
      @(negedge clk);
      bus.start = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_done_start: busy got %b want 0", bus.busy); end
      @(negedge clk);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL ign_latency: got %0d want 9", lat); end
      n_cmp++; if (wr_cnt - w0 !== 8) begin n_bad++; $display("FAIL ign_writes: got %0d want 8", wr_cnt - w0); end
      n_cmp++; if (regs[13] !== 32'h3) begin n_bad++; $display("FAIL ign_res: got %h want 00000003", regs[13]); end
      n_cmp++; if (regs[12] !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL ign_untouched: got %h want 5a5a5a5a", regs[12]); end
   endtask

   task automatic test_back_to_back;
      int n, w0;
      load(4'd11, 32'h0);
      bus.op = 3'b000; bus.rs1 = 4'd9; bus.rs2 = 4'd10; bus.rd = 4'd11; bus.start = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.done && n < 20);
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL b2b_first: got %0d want 9", n); end
      w0 = wr_cnt; n = 0;
      do begin @(negedge clk); n++; end while (!bus.done && n < 30);
      bus.start = 1'b0;
      n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_interval: got %0d want 10", n); end
      n_cmp++; if (wr_cnt - w0 !== 8) begin n_bad++; $display("FAIL b2b_writes: got %0d want 8", wr_cnt - w0); end
      n_cmp++; if (regs[11] !== 32'h3) begin n_bad++; $display("FAIL b2b_res: got %h want 00000003", regs[11]); end
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_abort;
      int n, lat, wr;
      logic seen;
      load(4'd13, 32'h1111_1111); load(4'd14, 32'h2222_2222); load(4'd15, 32'hAAAA_AAAA);
      bus.op = 3'b000; bus.rs1 = 4'd13; bus.rs2 = 4'd14; bus.rd = 4'd15; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; n = 0;
      while (bus.counter !== 3'd3 && n < 20) begin @(negedge clk); n++; end
      n_cmp++; if (bus.counter !== 3'd3) begin n_bad++; $display("FAIL abort_reach: counter got %0d want 3", bus.counter); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (bus.set_data !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_stop: got set=%b busy=%b want 0 0", bus.set_data, bus.busy); end
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen = seen | bus.done; end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
      n_cmp++; if (regs[15] !== 32'hAAAA_3333) begin n_bad++; $display("FAIL abort_partial: got %h want aaaa3333", regs[15]); end
      run_op(3'b000, 4'd13, 4'd14, 4'd15, lat, wr);
      n_cmp++; if (regs[15] !== 32'h3333_3333) begin n_bad++; $display("FAIL abort_rerun_res: got %h want 33333333", regs[15]); end
      n_cmp++; if (lat !== 9 || wr !== 8) begin n_bad++; $display("FAIL abort_rerun_timing: got lat=%0d wr=%0d want 9 8", lat, wr); end
      @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'd0; bus.rs1 = 4'd0; bus.rs2 = 4'd0; bus.rd = 4'd0;
      test_reset;
      test_add;
      test_sub;
      test_add_wrap;
      test_logic;
      test_ignore_start;
      test_back_to_back;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nibble_serial_alu.md
NIBBLE_SERIAL_ALU -- requirements
Module: nibble_serial_alu

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 4, giving the register-address width (16 registers).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port start, input, 1 bit: request one operation; sampled only in IDLE.
REQ-006 Port op, input, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS (copy rs1); 110/111 treated as PASS.
REQ-007 Ports rs1, rs2, rd, input, ADDR_BITS each: source and destination register addresses.
REQ-008 Port busy, output, 1 bit: high in RUN and DONE.
REQ-009 Port done, output, 1 bit: one-cycle pulse when the result is fully written.
REQ-010 Port carry, output, 1 bit: carry out of nibble 7 (ADD/SUB); 0 for logic ops and PASS.
REQ-011 Port zero, output, 1 bit: high when all 8 result nibbles were 0.
REQ-012 Port counter, output, 3 bits: nibble index driven to the register file.
REQ-013 Ports r1_addr, r2_addr, w_addr, output, ADDR_BITS each: register-file read and write addresses.
REQ-014 Port data_out1, data_out2, input, 4 bits each: register-file nibble `counter` of r1_addr and r2_addr, combinational.
REQ-015 Port data_in, output, 4 bits: result nibble to the register file.
REQ-016 Port set_data, output, 1 bit: register-file write strobe for nibble `counter` of w_addr.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, and DONE.
REQ-018 IDLE with start=1 SHALL latch op/rs1/rs2/rd, clear the carry and zero accumulators, and go to RUN with counter=0.
REQ-019 RUN SHALL last exactly 8 cycles with counter = 0,1,...,7; after counter=7 the FSM SHALL go to DONE.
REQ-020 DONE SHALL last exactly 1 cycle, then return to IDLE.
REQ-021 The start-to-done latency SHALL be 9 cycles (start sampled at edge T; done high in the cycle after edge T+8).
REQ-022 start SHALL be ignored in RUN and DONE; a new start SHALL be accepted only in IDLE, giving a minimum issue interval of 10 cycles.
REQ-023 In RUN, the outputs SHALL be r1_addr=rs1, r2_addr=rs2, w_addr=rd, set_data=1, and data_in = f(data_out1, data_out2, carry_reg), combinational.
REQ-024 ADD SHALL compute data_out1 + data_out2 + c, where c=0 at nibble 0 and c=the registered carry thereafter; bit 4 of the sum is registered as the next c.
REQ-025 SUB SHALL compute data_out1 + ~data_out2 + c, where c=1 at nibble 0 (two's complement); carry=1 means no borrow.
REQ-026 The logic ops and PASS SHALL compute bitwise; their internal carry is held at 0.
REQ-027 zero_acc SHALL be cleared at start and OR-accumulate (data_in != 0) each RUN cycle; zero = ~zero_acc, valid from DONE onward.
REQ-028 The carry and zero outputs SHALL hold their value from DONE until the next accepted start; during RUN they show the partial values and are not valid.
REQ-029 rd equal to rs1 or rs2 SHALL be legal: each nibble is read before its own write takes effect, and no nibble is reread.
REQ-030 Outside RUN, the outputs SHALL be set_data=0, counter=0, data_in=0, and addresses=0.
REQ-031 Arithmetic SHALL be modulo 2^32; overflow is reported only via carry, with no signed-overflow flag.

Reset
REQ-032 rst=1 SHALL, at the next edge, force IDLE and set counter=0, set_data=0, busy=0, done=0, carry=0, zero=0, and latched fields=0.
REQ-033 rst asserted in RUN SHALL abort the operation; already-written nibbles of rd remain modified, and no done pulse is issued.
REQ-034 rst has priority over start in the same cycle; start is dropped.

Verification
REQ-035 ADD: R1=0x0000_000F, R2=0x0000_0001, rd=R3 -> R3=0x0000_0010, carry=0, zero=0, done 9 cycles after start.
REQ-036 SUB: R1=R2=0x1234_5678, rd=R4 -> R4=0x0000_0000, carry=1, zero=1; then R1=0, R2=1 -> R4=0xFFFF_FFFF, carry=0.
REQ-037 ADD wrap: R1=0xFFFF_FFFF, R2=0x0000_0001, rd=R1 (aliased) -> R1=0x0000_0000, carry=1, zero=1.
REQ-038 XOR: R5=0xA5A5_A5A5 with itself, rd=R5 -> R5=0, zero=1; AND 0xF0F0_F0F0 & 0xFF00_FF00 -> 0xF000_F000.
REQ-039 start held high continuously -> operations issue exactly every 10 cycles; start pulses during RUN/DONE produce no extra writes.
REQ-040 rst pulsed at counter=3 during ADD -> set_data=0 at the next edge, no done pulse, R rd nibbles 0..3 updated and 4..7 unchanged; next start runs normally.
